board_input_cond: RTL

//  Conditions raw board inputs (KC705 BTNC, SW[3:0]) before they reach the kerygma SoC.
//  Per channel: 2-FF synchroniser into clk_i domain, counter-based debouncer, one-cycle rise pulse.
//  Top-level wiring: raw_i={SW,BTNC}; stable_o[4:1] -> kerygma gpio SW field; irq_o -> irq_btn_i.

---
 rtl/board_input_cond.sv | 72 +++++++
 1 files changed

// File: rtl/board_input_cond.sv
// board_input_cond: per-channel 2-FF synchroniser, counter debouncer and one-cycle edge pulses.
// Define INPUT_COND_FALL_PULSE_EN to add the fall_o pulse output.
module board_input_cond #(
    parameter int NCH = 5,
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W = $clog2(DEB_CYCLES + 1),
    parameter logic [NCH-1:0] RST_VAL = '0,
    parameter logic [NCH-1:0] IRQ_MASK = NCH'(1)
) (
    input  logic           clk_i,
    input  logic           arst_n_i,
    input  logic [NCH-1:0] raw_i,
    output logic [NCH-1:0] stable_o,
    output logic [NCH-1:0] rise_o,
    output logic           irq_o
`ifdef INPUT_COND_FALL_PULSE_EN
    ,
    output logic [NCH-1:0] fall_o
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic [NCH-1:0] s1, s2, upd;

    if (DEB_CYCLES < 1 || NCH < 1) begin : g_bad_cfg
        $fatal(1, "board_input_cond: DEB_CYCLES and NCH must be >= 1");
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= raw_i;
            s2 <= s1;
        end
    end

    // Count consecutive cycles that s2 disagrees with stable_o; any agreement restarts the count.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        assign upd[i] = (s2[i] != stable_o[i]) && (cnt == LAST);
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i)
                cnt <= '0;
            else
                cnt <= (s2[i] == stable_o[i] || cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            stable_o <= RST_VAL;
            rise_o   <= '0;
            irq_o    <= 1'b0;
        end else begin
            stable_o <= stable_o ^ upd;
            rise_o   <= upd & s2;
            irq_o    <= |(upd & s2 & IRQ_MASK);
        end
    end

`ifdef INPUT_COND_FALL_PULSE_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            fall_o <= '0;
        else
            fall_o <= upd & ~s2;
    end
`endif

endmodule
